sync_fifo_thr: RTL and testbench

//  Parametrised synchronous FIFO; next generation of the team FIFO. Adds occupancy count,

---
 rtl/sync_fifo_thr_if.sv | 34 +++
 rtl/sync_fifo_thr.sv | 83 ++++++++
 tb/tb_sync_fifo_thr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_thr_if.sv
// sync_fifo_thr_if: producer/consumer handshake bundle for sync_fifo_thr.
// slave is the FIFO side; master is the side that drives requests.
interface sync_fifo_thr_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  write_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  read_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_en, data_in, read_en,
    input  data_out, empty, full,
    input  almost_empty, almost_full,
    input  count, overflow, underflow
  );

  modport slave (
    input  write_en, data_in, read_en,
    output data_out, empty, full,
    output almost_empty, almost_full,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_thr.sv
// sync_fifo_thr: single-clock FIFO with count, threshold flags, error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read data.
module sync_fifo_thr #(
  parameter int FIFO_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_thr_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef logic [PW-1:0] ptr_t;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_q;
  logic                  udf_q;

  // Explicit wrap so any depth works, not just powers of two
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign rd_acc = bus.read_en & ~empty;
  assign wr_acc = bus.write_en & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      ovf_q <= bus.write_en & ~wr_acc;
      udf_q <= bus.read_en & ~rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= bus.data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= mem[rd_ptr];
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (count <= CW'(AEMPTY_THRESH));
  assign bus.almost_full  = (count >= CW'(AFULL_THRESH));
  assign bus.count        = count;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_thr.sv
// tb_sync_fifo_thr: queue-model checked bench for sync_fifo_thr.
// Runs a depth-16 and a depth-5 instance; honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_thr;
  logic clk = 1'b0;
  logic rst16 = 1'b1;
  logic rst5 = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sync_fifo_thr_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) b16 ();
  sync_fifo_thr_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(5))  b5 ();

  sync_fifo_thr #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(16),
    .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u16 (.clk(clk), .rst(rst16), .bus(b16));

  sync_fifo_thr #(
    .FIFO_WIDTH(8), .FIFO_DEPTH(5),
    .AFULL_THRESH(4), .AEMPTY_THRESH(1)
  ) u5 (.clk(clk), .rst(rst5), .bus(b5));

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words per instance
  logic [7:0] q16[$];
  logic [7:0] q5[$];
  logic [7:0] d16 = 8'h00;
  logic [7:0] d5 = 8'h00;
  bit o16, u16f, o5, u5f, v16, v5;

  always @(posedge clk) begin : m16
    bit ra, wa;
    if (rst16) begin
      q16.delete(); d16 = 8'h00; o16 = 0; u16f = 0;
    end else begin
      ra = b16.read_en && q16.size() > 0;
      wa = b16.write_en && (q16.size() < 16 || ra);
      o16 = b16.write_en && !wa;
      u16f = b16.read_en && !ra;
      if (ra) d16 = q16.pop_front();
      if (wa) q16.push_back(b16.data_in);
    end
    v16 = 1;
  end

  always @(posedge clk) begin : m5
    bit ra, wa;
    if (rst5) begin
      q5.delete(); d5 = 8'h00; o5 = 0; u5f = 0;
    end else begin
      ra = b5.read_en && q5.size() > 0;
      wa = b5.write_en && (q5.size() < 5 || ra);
      o5 = b5.write_en && !wa;
      u5f = b5.read_en && !ra;
      if (ra) d5 = q5.pop_front();
      if (wa) q5.push_back(b5.data_in);
    end
    v5 = 1;
  end

  always @(negedge clk) begin
    logic [7:0] e16, e5;
    if (v16) begin
`ifdef SYNC_FIFO_FWFT_EN
      e16 = q16.size() > 0 ? q16[0] : 8'h00;
`else
      e16 = d16;
`endif
      chk("cnt16", 32'(b16.count), q16.size());
      chk("dout16", 32'(b16.data_out), 32'(e16));
      chk("flags16",
          {b16.empty, b16.full, b16.almost_empty, b16.almost_full},
          {q16.size() == 0, q16.size() == 16,
           q16.size() <= 2, q16.size() >= 14});
      chk("err16", {b16.overflow, b16.underflow}, {o16, u16f});
    end
    if (v5) begin
`ifdef SYNC_FIFO_FWFT_EN
      e5 = q5.size() > 0 ? q5[0] : 8'h00;
`else
      e5 = d5;
`endif
      chk("cnt5", 32'(b5.count), q5.size());
      chk("dout5", 32'(b5.data_out), 32'(e5));
      chk("flags5",
          {b5.empty, b5.full, b5.almost_empty, b5.almost_full},
          {q5.size() == 0, q5.size() == 5,
           q5.size() <= 1, q5.size() >= 4});
      chk("err5", {b5.overflow, b5.underflow}, {o5, u5f});
    end
  end

  task automatic step16(logic w, logic [7:0] d, logic r);
    b16.write_en = w; b16.data_in = d; b16.read_en = r;
    @(posedge clk);
    @(negedge clk);
    b16.write_en = 0; b16.read_en = 0;
  endtask

  task automatic step5(logic w, logic [7:0] d, logic r);
    b5.write_en = w; b5.data_in = d; b5.read_en = r;
    @(posedge clk);
    @(negedge clk);
    b5.write_en = 0; b5.read_en = 0;
  endtask

  // Word delivered by one pop, in either read-timing build
  task automatic rd16(output logic [7:0] v);
`ifdef SYNC_FIFO_FWFT_EN
    v = b16.data_out;
    step16(0, 8'h00, 1);
`else
    step16(0, 8'h00, 1);
    v = b16.data_out;
`endif
  endtask

  task automatic rd5(output logic [7:0] v);
`ifdef SYNC_FIFO_FWFT_EN
    v = b5.data_out;
    step5(0, 8'h00, 1);
`else
    step5(0, 8'h00, 1);
    v = b5.data_out;
`endif
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] x;
    b16.write_en = 0; b16.read_en = 0; b16.data_in = 0;
    b5.write_en = 0; b5.read_en = 0; b5.data_in = 0;

    // Reset
    step16(0, 0, 0);
    step16(1, 8'h5A, 1);
    rst16 = 0;
    chk("rst_cnt", 32'(b16.count), 0);
    chk("rst_flags",
        {b16.empty, b16.full, b16.almost_empty, b16.almost_full}, 4'b1010);
    chk("rst_dout", 32'(b16.data_out), 0);
    chk("rst_err", {b16.overflow, b16.underflow}, 2'b00);

    // Fill to full, then overflow
    for (int i = 1; i <= 16; i++) begin
      step16(1, 8'(i), 0);
      if (i == 13) chk("af13", 32'(b16.almost_full), 0);
      if (i == 14) chk("af14", 32'(b16.almost_full), 1);
      if (i == 15) chk("full15", 32'(b16.full), 0);
    end
    chk("full16", {b16.full, 27'(0), b16.count}, {1'b1, 27'(0), 5'd16});
    step16(1, 8'h77, 0);
    chk("ovf", {b16.overflow, 27'(0), b16.count}, {1'b1, 27'(0), 5'd16});
    step16(0, 0, 0);
    chk("ovf_pulse", 32'(b16.overflow), 0);

    // Drain in order, then underflow
    for (int i = 1; i <= 16; i++) begin
      rd16(v);
      chk("drain", 32'(v), i);
      if (i == 13) chk("ae3", 32'(b16.almost_empty), 0);
      if (i == 14) chk("ae2", 32'(b16.almost_empty), 1);
    end
    step16(0, 0, 1);
    chk("udf", {b16.underflow, b16.empty}, 2'b11);
`ifndef SYNC_FIFO_FWFT_EN
    chk("udf_hold", 32'(b16.data_out), 32'h10);
`endif

    // Simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) step16(1, 8'(8'h40 + i), 0);
    step16(1, 8'hAA, 1);
    chk("sim_full", {b16.overflow, 27'(0), b16.count}, {1'b0, 27'(0), 5'd16});
    for (int i = 0; i < 16; i++) rd16(v);
    chk("sim_last", 32'(v), 32'hAA);
    step16(1, 8'h55, 1);
    chk("sim_empty", {b16.underflow, 27'(0), b16.count}, {1'b1, 27'(0), 5'd1});
    rd16(v);
    chk("sim_word", 32'(v), 32'h55);

    // Reset mid-operation with a write pending
    for (int i = 0; i < 7; i++) step16(1, 8'(8'h60 + i), 0);
    chk("pre_rst", 32'(b16.count), 7);
    rst16 = 1;
    step16(1, 8'h99, 0);
    rst16 = 0;
    chk("mid_rst", {b16.empty, 27'(0), b16.count}, {1'b1, 27'(0), 5'd0});
    step16(1, 8'h33, 0);
    rd16(v);
    chk("post_rst", 32'(v), 32'h33);

    // Randomised traffic, biased in phases to reach full and empty
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 64) % 2) ? 75 : 30;
      rst16 = ($urandom_range(0, 399) == 0);
      step16($urandom_range(0, 99) < p, 8'($urandom),
             $urandom_range(0, 99) < 100 - p);
    end
    rst16 = 0;

    // Depth 5: interleaved pairs force the pointers through the wrap
    step5(0, 0, 0);
    rst5 = 0;
    for (int i = 0; i < 12; i++) begin
      x = 8'(8'hC0 + i);
      step5(1, x, 0);
      rd5(v);
      chk("pair5", 32'(v), 32'(x));
    end
    chk("pair5_cnt", 32'(b5.count), 0);
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 16) % 2) ? 75 : 30;
      rst5 = ($urandom_range(0, 499) == 0);
      step5($urandom_range(0, 99) < p, 8'($urandom),
            $urandom_range(0, 99) < 100 - p);
    end
    rst5 = 0;
    step5(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
